aes_key_expand_seq: RTL and testbench

- Iterative AES-128 key schedule that generates the 44-word expanded key consumed by the cipher core's round-key mux.
- Computes one round key (4 words) per clock and needs 10 expansion cycles after a start pulse.
- Holds the full schedule in registers, with a valid flag, until the next start.
- Replaces purely combinational expansion so the long SubWord/XOR chain stays off the cipher's critical path.

---
 rtl/aes_key_expand_seq_if.sv | 12 +
 rtl/aes_key_expand_seq.sv | 124 ++++++++++++
 tb/tb_aes_key_expand_seq.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_expand_seq_if.sv
// Handshake and schedule bus between the key-expansion block and its user.
// master: the requester (drives start/key). slave: aes_key_expand_seq.
interface aes_key_expand_seq_if #(parameter int NR = 10);
  logic                  start;
  logic [127:0]          key;
  logic                  busy;
  logic                  key_valid;
  logic [128*(NR+1)-1:0] w;

  modport master (output start, key, input busy, key_valid, w);
  modport slave  (input start, key, output busy, key_valid, w);
endinterface

// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128 key schedule: one round key per clock, 10 clocks per key.
// The full 44-word schedule is held in registers and qualified by key_valid.
// Optional feature macro: AES_KEXP_KEY_CACHE_EN -- skip re-expansion when the
// requested key equals the last fully expanded one.
module aes_key_expand_seq #(
  parameter int NR = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_key_expand_seq_if.slave  bus
);

  typedef enum logic {IDLE, EXPAND} state_t;

  // AES S-box, entry x at bits [(255-x)*8 +: 8]
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX_TBL[{~a, 3'b000} +: 8];
  endfunction

  state_t               state, state_nxt;
  logic [0:NR][127:0]   sched;        // element r is round key r, round 0 in MSBs
  logic [3:0]           cnt;
  logic [7:0]           rcon;
  logic                 key_valid;
  logic                 load, step, done, hit;
  logic [3:0]           pidx;
  logic [127:0]         p;
  logic [31:0]          rot, sub, t, n0, n1, n2, n3;

  // previous round key and the next one derived from it
  assign pidx = cnt - 4'd1;
  assign p    = sched[pidx];
  assign rot  = {p[23:0], p[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign sub[b*8 +: 8] = sbox(rot[b*8 +: 8]);
  end

  assign t  = sub ^ {rcon, 24'h0};
  assign n0 = p[127:96] ^ t;
  assign n1 = n0 ^ p[95:64];
  assign n2 = n1 ^ p[63:32];
  assign n3 = n2 ^ p[31:0];

`ifdef AES_KEXP_KEY_CACHE_EN
  logic [127:0] cache_key;

  // key_valid=1 already implies cache_key belongs to a finished expansion
  assign hit = key_valid && (bus.key == cache_key);

  // remember the key whose schedule just completed
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cache_key <= '0;
    else if (done) cache_key <= sched[0];
  end
`else
  assign hit = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state and datapath strobes
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !hit) begin
          load      = 1'b1;
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        step = 1'b1;
        if (cnt == 4'(NR)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // schedule registers, round constant and round counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sched     <= '0;
      rcon      <= 8'h01;
      cnt       <= 4'd0;
      key_valid <= 1'b0;
    end else if (load) begin
      sched[0]  <= bus.key;
      rcon      <= 8'h01;
      cnt       <= 4'd1;
      key_valid <= 1'b0;
    end else if (step) begin
      sched[cnt] <= {n0, n1, n2, n3};
      rcon       <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      cnt        <= cnt + 4'd1;
      if (done) key_valid <= 1'b1;
    end
  end

  assign bus.busy      = (state == EXPAND);
  assign bus.key_valid = key_valid;
  assign bus.w         = sched;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Randomized bench for aes_key_expand_seq with a word-level FIPS-197 reference
// model (S-box derived from GF(2^8) inversion + affine map).
module tb_aes_key_expand_seq;
  localparam int NR = 10;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
`ifdef AES_KEXP_KEY_CACHE_EN
  localparam int REPEAT_BUSY = 0;
`else
  localparam int REPEAT_BUSY = 10;
`endif

  logic clk = 1'b0;
  logic rst;
  aes_key_expand_seq_if #(.NR(NR)) bus();
  aes_key_expand_seq #(.NR(NR)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [256];

  logic [1407:0] m_w     = '0;
  logic [1407:0] m_sched = '0;
  logic          m_busy  = 1'b0;
  logic          m_valid = 1'b0;
  int            m_cnt   = 0;
  logic [127:0]  m_last  = '0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] pr = 8'h00;
    logic [7:0] x  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) pr ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return pr;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (a != 0 && gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  // FIPS-197 word-recurrence expansion, packed in the DUT's w layout
  function automatic logic [1407:0] expand(input logic [127:0] k);
    logic [31:0] wd [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    logic [1407:0] r = '0;
    for (int i = 0; i < 4; i++) wd[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = wd[i-1];
      if (i % 4 == 0) begin
        tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      wd[i] = wd[i-4] ^ tmp;
    end
    for (int i = 0; i < 44; i++) r[(43 - i)*32 +: 32] = wd[i];
    return r;
  endfunction

  function automatic logic [127:0] rnd(input logic [1407:0] v, input int r);
    return v[(NR - r)*128 +: 128];
  endfunction

  // reference model: precomputed schedule revealed one round key per clock
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_w = '0; m_busy = 1'b0; m_valid = 1'b0; m_cnt = 0;
    end else if (m_busy) begin
      m_w[(NR - m_cnt)*128 +: 128] = rnd(m_sched, m_cnt);
      if (m_cnt == NR) begin
        m_busy  = 1'b0;
        m_valid = 1'b1;
      end
      m_cnt++;
    end else if (bus.start) begin
`ifdef AES_KEXP_KEY_CACHE_EN
      if (!(m_valid && bus.key == m_last)) begin
`else
      begin
`endif
        m_sched = expand(bus.key);
        m_w[1407:1280] = bus.key;
        m_last  = bus.key;
        m_busy  = 1'b1;
        m_valid = 1'b0;
        m_cnt   = 1;
      end
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    logic found = 1'b0;
    chk("busy", 128'(bus.busy), 128'(m_busy));
    chk("key_valid", 128'(bus.key_valid), 128'(m_valid));
    for (int r = 0; r <= NR; r++)
      if (!found && rnd(bus.w, r) !== rnd(m_w, r)) begin
        found = 1'b1;
        chk($sformatf("w_round%0d", r), rnd(bus.w, r), rnd(m_w, r));
      end
    if (!found) checks++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input logic [127:0] k);
    bus.start = 1'b1; bus.key = k;
    tick();
    bus.start = 1'b0; bus.key = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(output int nb);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.busy) break;
      nb++;
      tick();
    end
    if (bus.busy) begin
      checks++; errors++;
      $display("FAIL timeout busy still high got 1 exp 0");
    end
  endtask

  logic [127:0] pool [4];

  initial begin
    int nb;
    build_sbox();
    rst = 1'b1; bus.start = 1'b0; bus.key = '0;
    #3;
    chk("reset_busy", 128'(bus.busy), 128'd0);
    chk("reset_key_valid", 128'(bus.key_valid), 128'd0);
    chk("reset_w_zero", 128'(bus.w == '0), 128'd1);
    tick(); tick();
    rst = 1'b0;
    tick();

    // pin the reference model to published vectors
    chk("model_fips_r1", rnd(expand(FIPS_KEY), 1), FIPS_R1);
    chk("model_fips_r10", rnd(expand(FIPS_KEY), 10), FIPS_R10);
    chk("model_zero_r1", rnd(expand('0), 1), ZERO_R1);
    chk("model_zero_r10", rnd(expand('0), 10), ZERO_R10);

    // FIPS-197 vector
    pulse_start(FIPS_KEY);
    wait_done(nb);
    chk("fips_busy_cycles", 128'(nb), 128'd10);
    chk("fips_key_valid", 128'(bus.key_valid), 128'd1);
    chk("fips_r0", rnd(bus.w, 0), FIPS_KEY);
    chk("fips_r1", rnd(bus.w, 1), FIPS_R1);
    chk("fips_r10", rnd(bus.w, 10), FIPS_R10);

    // zero key, back-to-back with the previous completion
    pulse_start('0);
    wait_done(nb);
    chk("zero_busy_cycles", 128'(nb), 128'd10);
    chk("zero_r0", rnd(bus.w, 0), 128'd0);
    chk("zero_r1", rnd(bus.w, 1), ZERO_R1);
    chk("zero_r10", rnd(bus.w, 10), ZERO_R10);

    // start while busy is ignored
    pulse_start(FIPS_KEY);
    tick(); tick();
    bus.start = 1'b1; bus.key = '0;
    tick();
    bus.start = 1'b0;
    wait_done(nb);
    chk("ignore_busy_cycles", 128'(nb + 3), 128'd10);
    chk("ignore_r1", rnd(bus.w, 1), FIPS_R1);
    chk("ignore_r10", rnd(bus.w, 10), FIPS_R10);

    // reset mid-expansion takes effect before any edge
    pulse_start('0);
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 128'(bus.busy), 128'd0);
    chk("midrst_key_valid", 128'(bus.key_valid), 128'd0);
    chk("midrst_w_zero", 128'(bus.w == '0), 128'd1);
    tick();
    rst = 1'b0;
    tick();
    pulse_start(FIPS_KEY);
    wait_done(nb);
    chk("after_rst_busy_cycles", 128'(nb), 128'd10);
    chk("after_rst_r0", rnd(bus.w, 0), FIPS_KEY);
    chk("after_rst_r10", rnd(bus.w, 10), FIPS_R10);

    // repeat of the same key: cached or re-expanded depending on build
    pulse_start(FIPS_KEY);
    wait_done(nb);
    chk("repeat_busy_cycles", 128'(nb), 128'(REPEAT_BUSY));
    chk("repeat_key_valid", 128'(bus.key_valid), 128'd1);
    chk("repeat_r10", rnd(bus.w, 10), FIPS_R10);
    pulse_start('0);
    wait_done(nb);
    chk("newkey_busy_cycles", 128'(nb), 128'd10);
    chk("newkey_r10", rnd(bus.w, 10), ZERO_R10);

    // random traffic: starts during busy, repeated keys, occasional resets
    pool[0] = FIPS_KEY;
    pool[1] = '0;
    pool[2] = {$urandom, $urandom, $urandom, $urandom};
    pool[3] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 400; i++) begin
      bus.start = ($urandom_range(3) == 0);
      bus.key   = pool[$urandom_range(3)];
      rst       = ($urandom_range(99) == 0);
      tick();
    end
    bus.start = 1'b0; rst = 1'b0;
    repeat (15) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
